// File: rtl/cipher_pkg.sv
// Shared types and constants for the cipher sequencer: FSM state encoding,
// command opcodes, key/warm-up sizing and the keystream combine function.
package cipher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_KEY  = 2'b01,
    ST_WARM = 2'b10,
    ST_RUN  = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    OP_NOP      = 2'b00,
    OP_LOAD_KEY = 2'b01,
    OP_START    = 2'b10,
    OP_ABORT    = 2'b11
  } cmd_op_e;

  localparam int KEY_BYTES    = 4;
  localparam int WARMUP_STEPS = 16;

  localparam int KEY_CNT_W  = $clog2(KEY_BYTES);
  localparam int WARM_CNT_W = $clog2(WARMUP_STEPS);

  // Terminal counts: the counters start at zero, so the last step is N-1.
  localparam logic [KEY_CNT_W-1:0]  KEY_LAST  = KEY_CNT_W'(KEY_BYTES - 1);
  localparam logic [WARM_CNT_W-1:0] WARM_LAST = WARM_CNT_W'(WARMUP_STEPS - 1);

  // Stream cipher combine; XOR makes encrypt and decrypt the same operation.
  function automatic logic [7:0] apply_keystream(input logic [7:0] data,
                                                 input logic [7:0] ks);
    return data ^ ks;
  endfunction

endpackage

// File: rtl/cipher_out_buf.sv
// One-entry output register with valid/ready hold. The entry holds while
// valid_o & ~ready_i, and can be refilled in the same cycle it drains so a
// continuously ready consumer sees one byte per cycle. ena=0 freezes it.
module cipher_out_buf
  import cipher_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       clr_i,
  input  logic       load_i,
  input  logic [7:0] data_i,
  input  logic       ready_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       can_load_o
);

  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;

  // Next-state: clear beats load, load beats drain; nothing moves while disabled.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (ena) begin
      if (clr_i) begin
        valid_d = 1'b0;
      end else if (load_i) begin
        data_d  = data_i;
        valid_d = 1'b1;
      end else if (valid_q && ready_i) begin
        valid_d = 1'b0;
      end else begin
        valid_d = valid_q;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Entry register with asynchronous reset to empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign can_load_o = ~valid_q | ready_i;

endmodule

// File: rtl/cipher_sequencer.sv
// Cipher sequencer: loads a 4-byte key into an external keystream core,
// warms the core up for 16 steps, then XORs a byte stream with the keystream.
// ks_load/ks_step/ks_seed are decoded from state and the current handshakes
// so the core sees them in the same cycle the byte is accepted.
module cipher_sequencer
  import cipher_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  output logic        cmd_ready,
  input  logic [7:0]  din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [7:0]  dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        ks_load,
  output logic [7:0]  ks_seed,
  output logic        ks_step,
  input  logic [7:0]  ks_byte,
  output logic        busy,
  output logic [15:0] byte_cnt
);

  state_e                state_q, state_d;
  logic [KEY_CNT_W-1:0]  key_cnt_q, key_cnt_d;
  logic [WARM_CNT_W-1:0] warm_cnt_q, warm_cnt_d;
  logic                  key_loaded_q, key_loaded_d;
  logic [15:0]           byte_cnt_q, byte_cnt_d;

  cmd_op_e    op_s;
  logic       cmd_fire_s;
  logic       din_fire_s;
  logic       ks_load_s;
  logic       ks_step_s;
  logic       ob_load_s;
  logic       ob_clr_s;
  logic       ob_can_load_s;
  logic [7:0] cipher_s;

  assign op_s       = cmd_op_e'(cmd_op);
  assign cmd_ready  = (state_q == ST_IDLE) || (state_q == ST_RUN);
  assign din_ready  = (state_q == ST_KEY) || ((state_q == ST_RUN) && ob_can_load_s);
  assign cmd_fire_s = ena && cmd_valid && cmd_ready;
  assign din_fire_s = ena && din_valid && din_ready;
  assign cipher_s   = apply_keystream(din, ks_byte);

  // Next-state, counters and strobes; every transition is qualified by ena via the fire terms.
  always_comb begin
    state_d      = state_q;
    key_cnt_d    = key_cnt_q;
    warm_cnt_d   = warm_cnt_q;
    key_loaded_d = key_loaded_q;
    byte_cnt_d   = byte_cnt_q;
    ks_load_s    = 1'b0;
    ks_step_s    = 1'b0;
    ob_load_s    = 1'b0;
    ob_clr_s     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_fire_s) begin
          case (op_s)
            OP_LOAD_KEY: begin
              state_d      = ST_KEY;
              key_cnt_d    = '0;
              key_loaded_d = 1'b0;
              byte_cnt_d   = 16'h0000;
            end
            OP_START: begin
              if (key_loaded_q) begin
                state_d = ST_RUN;
              end else begin
                state_d = ST_IDLE;
              end
            end
            default: begin
              state_d = ST_IDLE;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_KEY: begin
        if (din_fire_s) begin
          ks_load_s = 1'b1;
          if (key_cnt_q == KEY_LAST) begin
            state_d    = ST_WARM;
            warm_cnt_d = '0;
          end else begin
            key_cnt_d = key_cnt_q + 1'b1;
          end
        end else begin
          state_d = ST_KEY;
        end
      end

      ST_WARM: begin
        if (ena) begin
          ks_step_s = 1'b1;
          if (warm_cnt_q == WARM_LAST) begin
            state_d      = ST_IDLE;
            key_loaded_d = 1'b1;
          end else begin
            warm_cnt_d = warm_cnt_q + 1'b1;
          end
        end else begin
          state_d = ST_WARM;
        end
      end

      ST_RUN: begin
        // ABORT wins over a byte accepted in the same cycle: that byte is dropped.
        if (cmd_fire_s && (op_s == OP_ABORT)) begin
          state_d  = ST_IDLE;
          ob_clr_s = 1'b1;
        end else if (din_fire_s) begin
          ks_step_s  = 1'b1;
          ob_load_s  = 1'b1;
          byte_cnt_d = byte_cnt_q + 16'd1;
        end else begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and counter registers; reset discards any partial key, warm-up or run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      key_cnt_q    <= '0;
      warm_cnt_q   <= '0;
      key_loaded_q <= 1'b0;
      byte_cnt_q   <= 16'h0000;
    end else begin
      state_q      <= state_d;
      key_cnt_q    <= key_cnt_d;
      warm_cnt_q   <= warm_cnt_d;
      key_loaded_q <= key_loaded_d;
      byte_cnt_q   <= byte_cnt_d;
    end
  end

  cipher_out_buf u_out_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .clr_i      (ob_clr_s),
    .load_i     (ob_load_s),
    .data_i     (cipher_s),
    .ready_i    (dout_ready),
    .data_o     (dout),
    .valid_o    (dout_valid),
    .can_load_o (ob_can_load_s)
  );

  assign ks_load  = ks_load_s;
  assign ks_step  = ks_step_s;
  // Seed is only meaningful alongside ks_load; it reads zero otherwise.
  assign ks_seed  = ks_load_s ? din : 8'h00;
  assign busy     = (state_q != ST_IDLE);
  assign byte_cnt = byte_cnt_q;

endmodule

// File: tb/tb_cipher_sequencer.sv
// Self-checking bench for cipher_sequencer: a negedge monitor counts keystream
// strobes and keeps a scoreboard of expected dout bytes; directed sequences
// cover key load, warm-up, streaming, back-pressure, enable pause, abort and reset.
module tb_cipher_sequencer;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic        cmd_ready;
  logic [7:0]  din;
  logic        din_valid;
  logic        din_ready;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        ks_load;
  logic [7:0]  ks_seed;
  logic        ks_step;
  logic [7:0]  ks_byte;
  logic        busy;
  logic [15:0] byte_cnt;

  int         n_checks;
  int         n_fail;
  int         ks_load_cnt;
  int         ks_step_cnt;
  int         exp_cnt;
  bit         run_phase;
  logic [7:0] exp_q [$];
  logic [7:0] key_bytes [0:3];

  localparam logic [1:0] C_NOP   = 2'b00;
  localparam logic [1:0] C_LOAD  = 2'b01;
  localparam logic [1:0] C_START = 2'b10;
  localparam logic [1:0] C_ABORT = 2'b11;

  cipher_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_ready  (cmd_ready),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .ks_load    (ks_load),
    .ks_seed    (ks_seed),
    .ks_step    (ks_step),
    .ks_byte    (ks_byte),
    .busy       (busy),
    .byte_cnt   (byte_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Monitor: strobe counters, seed check and output scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ks_load) begin
        ks_load_cnt++;
        chk("ks_seed", {24'd0, ks_seed}, {24'd0, din});
      end
      if (ks_step) ks_step_cnt++;
      if (ena && dout_valid && dout_ready) begin
        if (exp_q.size() == 0) chk("dout_unexpected", 32'd1, 32'd0);
        else chk("dout", {24'd0, dout}, {24'd0, exp_q.pop_front()});
      end
      if (run_phase && ena && din_valid && din_ready && !(cmd_valid && cmd_op == C_ABORT))
        exp_q.push_back(din ^ ks_byte);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command; entered and left at posedge+1.
  task automatic cmd(input logic [1:0] op);
    cmd_valid = 1'b1;
    cmd_op    = op;
    @(negedge clk);
    chk("cmd_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    cmd_op    = C_NOP;
  endtask

  // Offer one byte until accepted (bounded); optional random dout_ready.
  task automatic send_byte(input logic [7:0] b, input bit rand_rdy, input int max_wait);
    bit done;
    int n;
    done = 1'b0;
    n    = 0;
    din       = b;
    din_valid = 1'b1;
    while (!done && n < max_wait) begin
      if (rand_rdy) dout_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      done = ena && din_ready;
      tick();
      n++;
    end
    din_valid = 1'b0;
    if (done && run_phase) exp_cnt++;
    chk("din_accept", {31'd0, done}, 32'd1);
  endtask

  // Let the output drain with dout_ready high (bounded).
  task automatic drain();
    bit empty;
    empty = 1'b0;
    dout_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!dout_valid) begin
        empty = 1'b1;
        break;
      end
      tick();
    end
    tick();
    chk("drain", {31'd0, empty}, 32'd1);
  endtask

  task automatic load_key();
    int l0;
    l0 = ks_load_cnt;
    for (int i = 0; i < 4; i++) send_byte(key_bytes[i], 1'b0, 10);
    chk("ks_load_pulses", ks_load_cnt - l0, 32'd4);
  endtask

  initial begin
    int s0;
    int l0;
    int c0;
    bit seen;
    n_checks = 0; n_fail = 0; ks_load_cnt = 0; ks_step_cnt = 0; exp_cnt = 0;
    run_phase = 1'b0;
    key_bytes[0] = 8'h12; key_bytes[1] = 8'h34; key_bytes[2] = 8'h56; key_bytes[3] = 8'h78;
    rst_n = 1'b0; ena = 1'b1; cmd_valid = 1'b0; cmd_op = C_NOP;
    din = 8'h00; din_valid = 1'b0; dout_ready = 1'b1; ks_byte = 8'h00;

    // Reset values
    #3;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
    chk("rst_dout", {24'd0, dout}, 32'd0);
    chk("rst_ks_load", {31'd0, ks_load}, 32'd0);
    chk("rst_ks_step", {31'd0, ks_step}, 32'd0);
    chk("rst_ks_seed", {24'd0, ks_seed}, 32'd0);
    chk("rst_byte_cnt", {16'd0, byte_cnt}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // START without a key stays idle
    s0 = ks_step_cnt;
    cmd(C_START);
    @(negedge clk);
    chk("nokey_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("nokey_steps", ks_step_cnt - s0, 32'd0);

    // Key load, warm-up with a 3-cycle enable pause in the middle
    cmd(C_LOAD);
    @(negedge clk);
    chk("key_busy", {31'd0, busy}, 32'd1);
    chk("key_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    tick();
    s0 = ks_step_cnt;
    load_key();
    chk("key_no_steps", ks_step_cnt - s0, 32'd0);
    tick();
    tick();
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("warm_pause_step", {31'd0, ks_step}, 32'd0);
      chk("warm_pause_busy", {31'd0, busy}, 32'd1);
      tick();
    end
    ena = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    tick();
    chk("warm_done", {31'd0, seen}, 32'd1);
    chk("warm_steps", ks_step_cnt - s0, 32'd16);

    // START with key loaded enters RUN
    cmd(C_START);
    run_phase = 1'b1;
    @(negedge clk);
    chk("run_busy", {31'd0, busy}, 32'd1);
    chk("run_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("run_din_ready", {31'd0, din_ready}, 32'd1);
    tick();

    // Stream three bytes against a constant keystream byte
    s0 = ks_step_cnt;
    dout_ready = 1'b1;
    ks_byte = 8'hA5;
    send_byte(8'h01, 1'b0, 10);
    send_byte(8'h02, 1'b0, 10);
    send_byte(8'h03, 1'b0, 10);
    @(negedge clk);
    chk("stream_last_valid", {31'd0, dout_valid}, 32'd1);
    chk("stream_last_dout", {24'd0, dout}, 32'hA6);
    chk("stream_byte_cnt", {16'd0, byte_cnt}, 32'd3);
    tick();
    @(negedge clk);
    chk("stream_idle_valid", {31'd0, dout_valid}, 32'd0);
    tick();
    chk("stream_steps", ks_step_cnt - s0, 32'd3);

    // Back-pressure: output held, no further acceptance or stepping
    dout_ready = 1'b0;
    ks_byte = 8'h3C;
    send_byte(8'h10, 1'b0, 10);
    s0 = ks_step_cnt;
    din = 8'h20;
    din_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_din_ready", {31'd0, din_ready}, 32'd0);
      chk("hold_valid", {31'd0, dout_valid}, 32'd1);
      chk("hold_dout", {24'd0, dout}, 32'h2C);
      tick();
    end
    chk("hold_steps", ks_step_cnt - s0, 32'd0);
    din_valid = 1'b0;
    dout_ready = 1'b1;
    ks_byte = 8'h0F;
    send_byte(8'h20, 1'b0, 10);
    drain();

    // LOAD_KEY while running is accepted and ignored
    cmd(C_LOAD);
    @(negedge clk);
    chk("run_ignore_busy", {31'd0, busy}, 32'd1);
    chk("run_ignore_cnt", {16'd0, byte_cnt}, exp_cnt);
    tick();

    // Random stream with random keystream bytes and random back-pressure
    for (int i = 0; i < 20; i++) begin
      ks_byte = 8'($urandom_range(0, 255));
      send_byte(8'($urandom_range(0, 255)), 1'b1, 60);
    end
    drain();
    chk("rand_byte_cnt", {16'd0, byte_cnt}, exp_cnt);
    chk("rand_sb_empty", exp_q.size(), 32'd0);

    // Enable pause with output pending and consumer ready
    dout_ready = 1'b0;
    ks_byte = 8'h77;
    send_byte(8'h42, 1'b0, 10);
    c0 = exp_cnt;
    ena = 1'b0;
    dout_ready = 1'b1;
    din = 8'h11;
    din_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("pause_valid", {31'd0, dout_valid}, 32'd1);
      chk("pause_dout", {24'd0, dout}, 32'h35);
      chk("pause_step", {31'd0, ks_step}, 32'd0);
      tick();
    end
    chk("pause_byte_cnt", {16'd0, byte_cnt}, c0);
    din_valid = 1'b0;
    ena = 1'b1;
    drain();

    // ABORT with output pending and a byte offered in the same cycle
    dout_ready = 1'b0;
    ks_byte = 8'h5A;
    send_byte(8'h55, 1'b0, 10);
    s0 = ks_step_cnt;
    c0 = exp_cnt;
    dout_ready = 1'b1;
    din = 8'h99;
    din_valid = 1'b1;
    cmd_valid = 1'b1;
    cmd_op = C_ABORT;
    @(negedge clk);
    chk("abort_step", {31'd0, ks_step}, 32'd0);
    tick();
    cmd_valid = 1'b0;
    cmd_op = C_NOP;
    din_valid = 1'b0;
    run_phase = 1'b0;
    @(negedge clk);
    chk("abort_valid", {31'd0, dout_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_byte_cnt", {16'd0, byte_cnt}, c0);
    tick();
    chk("abort_steps", ks_step_cnt - s0, 32'd0);
    chk("abort_sb_empty", exp_q.size(), 32'd0);

    // LOAD_KEY clears the byte count; reset during warm-up step 8
    cmd(C_LOAD);
    @(negedge clk);
    chk("reload_byte_cnt", {16'd0, byte_cnt}, 32'd0);
    tick();
    load_key();
    s0 = ks_step_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (ks_step_cnt - s0 >= 8) break;
      @(posedge clk);
      #1;
    end
    chk("warm_mid_steps", ks_step_cnt - s0, 32'd8);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ks_step", {31'd0, ks_step}, 32'd0);
    chk("mid_rst_ks_load", {31'd0, ks_load}, 32'd0);
    chk("mid_rst_ks_seed", {24'd0, ks_seed}, 32'd0);
    chk("mid_rst_dout", {24'd0, dout}, 32'd0);
    chk("mid_rst_dout_valid", {31'd0, dout_valid}, 32'd0);
    chk("mid_rst_byte_cnt", {16'd0, byte_cnt}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    s0 = ks_step_cnt;
    l0 = ks_load_cnt;
    cmd(C_START);
    @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    tick();
    tick();
    tick();
    chk("post_rst_steps", ks_step_cnt - s0, 32'd0);
    chk("post_rst_loads", ks_load_cnt - l0, 32'd0);
    chk("final_sb_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cipher_sequencer.md
CIPHER_SEQUENCER -- requirements
Module: cipher_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port: ena  input  1  global enable; 0 freezes all state and suppresses every handshake.
REQ-004 SHALL have port: cmd_valid  input  1  command offered.
REQ-005 SHALL have port: cmd_op  input  2  00 NOP, 01 LOAD_KEY, 10 START, 11 ABORT.
REQ-006 SHALL have port: cmd_ready  output  1  command accepted when cmd_valid&cmd_ready&ena.
REQ-007 SHALL have port: din  input  8  key byte (KEY state) or plaintext/ciphertext byte (RUN state).
REQ-008 SHALL have ports: din_valid  input  1; din_ready  output  1  byte handshake.
REQ-009 SHALL have ports: dout  output  8; dout_valid  output  1; dout_ready  input  1  result handshake.
REQ-010 SHALL have ports: ks_load  output  1; ks_seed  output  8  one key byte shifted into keystream core per ks_load pulse.
REQ-011 SHALL have ports: ks_step  output  1; ks_byte  input  8  keystream core advances one byte per ks_step; ks_byte is the current byte, valid combinationally.
REQ-012 SHALL have ports: busy  output  1; byte_cnt  output  16  processed-byte count.

Function
REQ-013 SHALL implement FSM states IDLE, KEY, WARM, RUN.
REQ-014 IDLE: cmd_ready=1; LOAD_KEY -> KEY with key counter=0; START -> RUN only if key_loaded=1, else stays IDLE; NOP/ABORT stay IDLE.
REQ-015 KEY: din_ready=1; each accepted byte drives ks_load=1, ks_seed=din the same cycle; after 4th byte -> WARM, warm counter=0.
REQ-016 WARM: ks_step=1 every enabled cycle for exactly 16 cycles, then -> IDLE, key_loaded set to 1.
REQ-017 RUN: din_ready = ~dout_valid | dout_ready; accepted byte registers dout=din^ks_byte, dout_valid=1 next cycle, ks_step=1 the same cycle; byte_cnt increments, wraps 0xFFFF->0x0000.
REQ-018 Encrypt and decrypt SHALL be identical (XOR); no mode input.
REQ-019 dout/dout_valid SHALL hold stable while dout_valid&~dout_ready; full throughput of one byte per cycle when dout_ready=1.
REQ-020 cmd_ready SHALL be 1 in IDLE and RUN, 0 in KEY and WARM; only ABORT is acted on in RUN (others accepted and ignored).
REQ-021 ABORT in RUN -> IDLE next cycle; pending dout_valid SHALL be cleared; a din accepted in the same cycle as ABORT is discarded (no ks_step).
REQ-022 LOAD_KEY SHALL clear key_loaded and byte_cnt on acceptance.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 ena=0 mid-KEY/WARM/RUN SHALL pause counters and outputs; resumption continues exactly where paused.

Reset
REQ-025 rst_n=0 SHALL asynchronously force state=IDLE, key_loaded=0, byte_cnt=0, dout=0x00, dout_valid=0, ks_load=0, ks_step=0, ks_seed=0x00.
REQ-026 Reset mid-operation SHALL discard any partial key, warmup or pending output; no further ks_load/ks_step until a new command.

Structure
REQ-027 cipher_pkg SHALL hold the state enum, cmd_op codes, KEY_BYTES=4, WARMUP_STEPS=16.
REQ-028 The one-entry output register with valid/ready hold SHALL be a sub-module cipher_out_buf.
REQ-029 ks_load/ks_step SHALL be combinational from state and handshakes; all other outputs registered.

Verification
REQ-030 LOAD_KEY then din 0x12,0x34,0x56,0x78 -> 4 ks_load pulses with matching ks_seed, then exactly 16 ks_step cycles, busy falls, state IDLE.
REQ-031 START without key loaded -> state stays IDLE, no ks_step, busy=0.
REQ-032 RUN, ks_byte=0xA5, din 0x01,0x02,0x03 with dout_ready=1 -> dout 0xA4,0xA7,0xA6 one cycle later each, byte_cnt=3.
REQ-033 RUN, dout_ready=0 for 3 cycles -> dout held, din_ready=0 after first byte, no extra ks_step.
REQ-034 ABORT with dout_valid=1 and din_valid=1 -> IDLE next cycle, dout_valid=0, no ks_step, byte_cnt unchanged.
REQ-035 rst_n low during WARM cycle 8 -> all outputs at reset values immediately; START afterwards stays IDLE.
